// File: rtl/dmem_arbiter_pkg.sv
// dmem_pkg: shared encodings for the dmem arbiter slice.
// RW codes, FSM states and requester port indices.
package dmem_pkg;

  typedef logic [1:0] rw_t;

  localparam rw_t DMEM_NOP = 2'b00;
  localparam rw_t DMEM_WR  = 2'b01;
  localparam rw_t DMEM_RD  = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACCESS,
    ST_RESP
  } state_e;

  localparam logic PORT0 = 1'b0;
  localparam logic PORT1 = 1'b1;

  function automatic logic rw_legal(input rw_t rw);
    return (rw == DMEM_WR) || (rw == DMEM_RD);
  endfunction

endpackage

// File: rtl/dmem_arbiter_if.sv
// dmem_arbiter_if: one requester port of the dmem arbiter.
// master = requester side, slave = arbiter side.
interface dmem_arbiter_if
  import dmem_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);

  logic                req;
  rw_t                 rw;
  logic [DATA_W/8-1:0] we;
  logic [ADDR_W-1:0]   addr;
  logic [DATA_W-1:0]   wdata;
  logic                gnt;
  logic                rvalid;
  logic [DATA_W-1:0]   rdata;
  logic                err;

  modport master (
    output req, rw, we, addr, wdata,
    input  gnt, rvalid, rdata, err
  );

  modport slave (
    input  req, rw, we, addr, wdata,
    output gnt, rvalid, rdata, err
  );

endinterface

// File: rtl/dmem_arbiter_pick.sv
// dmem_arb_pick: winner select for the two dmem requesters.
// DMEM_ARB_RR_EN: round-robin; otherwise port 0 first with port-1 starve guard.
module dmem_arb_pick
  import dmem_pkg::*;
#(
  parameter int STARVE_LIMIT = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic req0_i,
  input  logic req1_i,
  input  logic take_i,
  output logic win_o
);

`ifdef DMEM_ARB_RR_EN
  logic prio_q, prio_d;

  // prio_q is the port favoured on the next contested pick
  assign win_o  = (req0_i && req1_i) ? prio_q : req1_i;
  assign prio_d = take_i ? ~win_o : prio_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) prio_q <= PORT0;
    else     prio_q <= prio_d;
  end
`else
  localparam int CW = $clog2(STARVE_LIMIT + 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          starved;

  assign starved = (cnt_q == CW'(STARVE_LIMIT));
  assign win_o   = req1_i && (!req0_i || starved);

  always_comb begin
    cnt_d = cnt_q;
    if (take_i) begin
      if (win_o)
        cnt_d = '0;
      else if (req1_i && !starved)
        cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end
`endif

endmodule

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares one dmem port between two requesters.
// Arbitration policy selected by DMEM_ARB_RR_EN (see dmem_arb_pick).
module dmem_arbiter
  import dmem_pkg::*;
#(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                clk,
  input  logic                rst,
  dmem_arbiter_if.slave       m0,
  dmem_arbiter_if.slave       m1,
  output rw_t                 dmemRW,
  output logic [DATA_W/8-1:0] w_en,
  output logic [ADDR_W-1:0]   addr,
  output logic [DATA_W-1:0]   din,
  input  logic [DATA_W-1:0]   dout,
  input  logic                outofbound
);

  localparam int BE_W = DATA_W / 8;

  state_e            state_q, state_d;
  rw_t               rw_q;
  logic [BE_W-1:0]   we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic              own_q;
  logic [DATA_W-1:0] rdata_q;
  logic              err_q;

  logic arb, take, win;
  logic acc, rsp, legal, wr;

  assign arb  = (state_q == ST_IDLE) || (state_q == ST_RESP);
  assign take = arb && (m0.req || m1.req) && !rst;

  dmem_arb_pick #(
    .STARVE_LIMIT(STARVE_LIMIT)
  ) u_pick (
    .clk    (clk),
    .rst    (rst),
    .req0_i (m0.req),
    .req1_i (m1.req),
    .take_i (take),
    .win_o  (win)
  );

  assign acc   = (state_q == ST_ACCESS);
  assign rsp   = (state_q == ST_RESP);
  assign legal = rw_legal(rw_q);
  assign wr    = acc && (rw_q == DMEM_WR);

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:   if (take) state_d = ST_ACCESS;
      ST_ACCESS: state_d = ST_RESP;
      ST_RESP:   state_d = take ? ST_ACCESS : ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      rw_q    <= DMEM_NOP;
      we_q    <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      own_q   <= PORT0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (take) begin
        own_q   <= win;
        rw_q    <= win ? m1.rw    : m0.rw;
        we_q    <= win ? m1.we    : m0.we;
        addr_q  <= win ? m1.addr  : m0.addr;
        wdata_q <= win ? m1.wdata : m0.wdata;
      end
      // response is captured at the edge that closes ACCESS
      if (acc) begin
        err_q   <= outofbound || !legal;
        rdata_q <= (rw_q == DMEM_RD && !outofbound) ? dout : '0;
      end
    end
  end

  assign dmemRW = (acc && legal) ? rw_q : DMEM_NOP;
  assign addr   = (acc && legal) ? addr_q : '0;
  assign w_en   = wr ? we_q : '0;
  assign din    = wr ? wdata_q : '0;

  assign m0.gnt    = take && (win == PORT0);
  assign m1.gnt    = take && (win == PORT1);
  assign m0.rvalid = rsp && (own_q == PORT0);
  assign m1.rvalid = rsp && (own_q == PORT1);
  assign m0.rdata  = m0.rvalid ? rdata_q : '0;
  assign m1.rdata  = m1.rvalid ? rdata_q : '0;
  assign m0.err    = m0.rvalid && err_q;
  assign m1.err    = m1.rvalid && err_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: vectors, directed sequences and random traffic
// against a transaction-level model of the dmem arbiter.
module tb_dmem_arbiter;
  import dmem_pkg::*;

  localparam int LIMIT = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [1:0]  dmemRW;
  logic [3:0]  w_en;
  logic [31:0] addr, din, dout;
  logic        outofbound;

  always #5 clk = ~clk;

  dmem_arbiter_if m0 ();
  dmem_arbiter_if m1 ();

  dmem_arbiter #(
    .ADDR_W(32), .DATA_W(32), .STARVE_LIMIT(LIMIT)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .m0         (m0),
    .m1         (m1),
    .dmemRW     (dmemRW),
    .w_en       (w_en),
    .addr       (addr),
    .din        (din),
    .dout       (dout),
    .outofbound (outofbound)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%h want=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- dmem environment and reference memory
  logic [31:0] mem     [logic [31:0]];
  logic [31:0] ref_mem [logic [31:0]];
  logic [31:0] wtmp;

  function automatic logic inb(input logic [31:0] a);
    return (a[31:12] == 20'h00100) || (a[31:12] == 20'h80000);
  endfunction

  function automatic logic [31:0] mrd(input logic [31:0] a);
    logic [31:0] k;
    k = {a[31:2], 2'b00};
    return mem.exists(k) ? mem[k] : 32'h0;
  endfunction

  always_comb begin
    outofbound = (dmemRW != 2'b00) && !inb(addr);
    dout = (dmemRW == 2'b10 && inb(addr)) ? mrd(addr) : 32'h0;
  end

  always @(posedge clk) begin
    if (dmemRW == 2'b01 && inb(addr)) begin
      wtmp = mrd(addr);
      for (int b = 0; b < 4; b++)
        if (w_en[b]) wtmp[8*b +: 8] = din[8*b +: 8];
      mem[{addr[31:2], 2'b00}] = wtmp;
    end
  end

  function automatic void ref_txn(input logic [1:0] rw,
    input logic [3:0] we, input logic [31:0] a, input logic [31:0] wd,
    output logic [31:0] rd, output logic er);
    logic [31:0] k, w;
    k  = {a[31:2], 2'b00};
    rd = 32'h0;
    er = 1'b0;
    if (!(rw == 2'b01 || rw == 2'b10) || !inb(a)) begin
      er = 1'b1;
    end else if (rw == 2'b10) begin
      rd = ref_mem.exists(k) ? ref_mem[k] : 32'h0;
    end else begin
      w = ref_mem.exists(k) ? ref_mem[k] : 32'h0;
      for (int b = 0; b < 4; b++)
        if (we[b]) w[8*b +: 8] = wd[8*b +: 8];
      ref_mem[k] = w;
    end
  endfunction

  // ---------------- requester helpers
  task automatic drive(input bit p, input logic r, input logic [1:0] rw,
    input logic [3:0] we, input logic [31:0] a, input logic [31:0] wd);
    if (p) begin
      m1.req = r; m1.rw = rw; m1.we = we; m1.addr = a; m1.wdata = wd;
    end else begin
      m0.req = r; m0.rw = rw; m0.we = we; m0.addr = a; m0.wdata = wd;
    end
  endtask

  function automatic logic gnt_of(input bit p);
    return p ? m1.gnt : m0.gnt;
  endfunction

  task automatic wait_gnt(input bit p, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (gnt_of(p)) begin ok = 1'b1; break; end
    end
    if (!ok) begin
      checks++; errors++;
      $display("FAIL gnt_timeout port=%0d got=0 want=1", p);
    end
  endtask

  // ---------------- transaction-level monitor / scoreboard
  typedef struct {
    bit          port;
    logic [1:0]  rw;
    logic [3:0]  we;
    logic [31:0] rdata;
    logic        err;
  } pend_t;

  bit    mon_en = 1'b0;
  int    cyc, last_g;
  bit    pend_v, rr_last;
  int    starve;
  pend_t pend;
  bit    m_take, m_win;
  logic [1:0]  xrw;
  logic [3:0]  xwe;
  logic [31:0] xa, xwd, xrd;
  logic        xer;

  always @(negedge clk) begin
    if (!mon_en) begin
      cyc = 0; last_g = -10; pend_v = 0; rr_last = 1; starve = 0;
    end else begin
      m_take = (cyc >= last_g + 2) && (m0.req || m1.req);
`ifdef DMEM_ARB_RR_EN
      m_win = (m0.req && m1.req) ? !rr_last : m1.req;
`else
      m_win = m1.req && (!m0.req || starve == LIMIT);
`endif
      chk("mon_gnt", {m1.gnt, m0.gnt},
          {m_take && m_win, m_take && !m_win});
      if (pend_v && cyc == last_g + 1)
        chk("mon_access", {dmemRW, w_en},
            {((pend.rw == 2'b01 || pend.rw == 2'b10) ? pend.rw : 2'b00),
             (pend.rw == 2'b01 ? pend.we : 4'h0)});
      if (pend_v && cyc == last_g + 2) begin
        chk("mon_rvalid", {m1.rvalid, m0.rvalid},
            pend.port ? 2'b10 : 2'b01);
        chk("mon_rsp", pend.port ? {m1.err, m1.rdata} : {m0.err, m0.rdata},
            {pend.err, pend.rdata});
        pend_v = 0;
      end else begin
        chk("mon_no_rvalid", {m1.rvalid, m0.rvalid}, 2'b00);
      end
      if (m_take) begin
        xrw = m_win ? m1.rw : m0.rw;
        xwe = m_win ? m1.we : m0.we;
        xa  = m_win ? m1.addr : m0.addr;
        xwd = m_win ? m1.wdata : m0.wdata;
        ref_txn(xrw, xwe, xa, xwd, xrd, xer);
        pend = '{m_win, xrw, xwe, xrd, xer};
        pend_v = 1; last_g = cyc;
        rr_last = m_win;
        if (m_win) starve = 0;
        else if (m1.req && starve < LIMIT) starve++;
      end
      cyc++;
    end
  end

  // ---------------- stimulus
  typedef struct {
    bit          port;
    logic [1:0]  rw;
    logic [3:0]  we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        err;
  } vec_t;

  vec_t vecs[12];

  task automatic do_reset();
    @(posedge clk); #1;
    mon_en = 0; rst = 1;
    drive(0, 0, 2'b00, 4'h0, 32'h0, 32'h0);
    drive(1, 0, 2'b00, 4'h0, 32'h0, 32'h0);
    repeat (2) @(posedge clk);
    #1; rst = 0; mon_en = 1;
  endtask

  task automatic do_txn(input vec_t v);
    bit ok;
    @(posedge clk); #1;
    drive(v.port, 1, v.rw, v.we, v.addr, v.wdata);
    wait_gnt(v.port, ok);
    @(posedge clk); #1;
    drive(v.port, 0, 2'b00, 4'h0, 32'h0, 32'h0);
    if (ok) begin
      @(negedge clk);
      chk("vec_dmemRW", dmemRW,
          (v.rw == 2'b01 || v.rw == 2'b10) ? v.rw : 2'b00);
      @(negedge clk);
      chk("vec_rvalid", {m1.rvalid, m0.rvalid}, v.port ? 2'b10 : 2'b01);
      chk("vec_rdata", v.port ? m1.rdata : m0.rdata, v.rdata);
      chk("vec_err", v.port ? m1.err : m0.err, v.err);
    end
  endtask

  task automatic rnd_req(input bit p);
    logic [1:0]  rw;
    logic [31:0] a;
    int k, j;
    k = $urandom_range(0, 9);
    if (k == 0)     rw = $urandom_range(0, 1) ? 2'b11 : 2'b00;
    else if (k < 5) rw = 2'b01;
    else            rw = 2'b10;
    j = $urandom_range(0, 8);
    if (j == 8)     a = 32'h40000010;
    else if (j < 4) a = 32'h00100000 + 32'(4 * j);
    else            a = 32'h80000000 + 32'(4 * (j - 4));
    drive(p, 1, rw, 4'($urandom_range(0, 15)), a, $urandom);
  endtask

  bit   ok, g0, g1;
  bit   gseq[10];
  int   n;
  int   gc[$];
  int   exp_w;

  initial begin
    #1000000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1);
  end

  initial begin
    mem[32'h00100000] = 32'h11987251;
    mem[32'h00100004] = 32'h18790475;
    mem[32'h00100008] = 32'h10257233;
    mem[32'h0010000C] = 32'hDEADBEEF;
    ref_mem = mem;
    drive(0, 0, 2'b00, 4'h0, 32'h0, 32'h0);
    drive(1, 0, 2'b00, 4'h0, 32'h0, 32'h0);

    vecs[0]  = '{0, 2'b10, 4'h0, 32'h00100000, 32'h0, 32'h11987251, 0};
    vecs[1]  = '{0, 2'b01, 4'h1, 32'h80000000, 32'h20221118, 32'h0, 0};
    vecs[2]  = '{0, 2'b10, 4'h0, 32'h80000000, 32'h0, 32'h00000018, 0};
    vecs[3]  = '{1, 2'b11, 4'hF, 32'h00100000, 32'h55, 32'h0, 1};
    vecs[4]  = '{1, 2'b10, 4'h0, 32'h40000000, 32'h0, 32'h0, 1};
    vecs[5]  = '{1, 2'b01, 4'h0, 32'h80000004, 32'hFF, 32'h0, 0};
    vecs[6]  = '{1, 2'b10, 4'h0, 32'h80000004, 32'h0, 32'h0, 0};
    vecs[7]  = '{0, 2'b00, 4'h0, 32'h00100004, 32'h0, 32'h0, 1};
    vecs[8]  = '{1, 2'b01, 4'hF, 32'h80000008, 32'hA5A55A5A, 32'h0, 0};
    vecs[9]  = '{0, 2'b10, 4'h0, 32'h80000008, 32'h0, 32'hA5A55A5A, 0};
    vecs[10] = '{1, 2'b10, 4'h0, 32'h00100008, 32'h0, 32'h10257233, 0};
    vecs[11] = '{0, 2'b01, 4'hF, 32'h90000000, 32'h1, 32'h0, 1};

    // reset state
    repeat (2) @(negedge clk);
    chk("rst_bus", {dmemRW, w_en, din}, 0);
    chk("rst_addr", addr, 0);
    chk("rst_hs", {m0.gnt, m1.gnt, m0.rvalid, m1.rvalid, m0.err, m1.err}, 0);
    chk("rst_rdata", {m0.rdata, m1.rdata}, 0);
    @(posedge clk); #1;
    rst = 0; mon_en = 1;

    foreach (vecs[i]) do_txn(vecs[i]);

    // contention from a fresh arbiter
    do_reset();
    drive(0, 1, 2'b10, 4'h0, 32'h00100004, 32'h0);
    drive(1, 1, 2'b10, 4'h0, 32'h00100008, 32'h0);
    n = 0;
    for (int c = 0; c < 60 && n < 10; c++) begin
      @(negedge clk);
      if (m0.rvalid) chk("cont_rd0", m0.rdata, 32'h18790475);
      if (m1.rvalid) chk("cont_rd1", m1.rdata, 32'h10257233);
      if (m0.gnt || m1.gnt) begin
        gseq[n] = m1.gnt;
        n++;
      end
    end
    chk("cont_count", n, 10);
    for (int i = 0; i < n; i++) begin
`ifdef DMEM_ARB_RR_EN
      exp_w = i % 2;
`else
      exp_w = (i % 5 == 4) ? 1 : 0;
`endif
      chk("cont_order", gseq[i], exp_w);
    end
    @(posedge clk); #1;
    drive(0, 0, 2'b00, 4'h0, 32'h0, 32'h0);
    drive(1, 0, 2'b00, 4'h0, 32'h0, 32'h0);
    repeat (4) @(negedge clk);

    // reset during ACCESS
    @(posedge clk); #1;
    drive(0, 1, 2'b10, 4'h0, 32'h00100000, 32'h0);
    wait_gnt(0, ok);
    @(posedge clk); #1;
    drive(0, 0, 2'b00, 4'h0, 32'h0, 32'h0);
    chk("pre_rst_access", dmemRW, 2'b10);
    mon_en = 0; rst = 1;
    #1;
    chk("midrst_bus", {dmemRW, w_en, din}, 0);
    chk("midrst_addr", addr, 0);
    chk("midrst_hs", {m0.gnt, m1.gnt, m0.rvalid, m1.rvalid}, 0);
    repeat (2) begin
      @(negedge clk);
      chk("midrst_no_rvalid", {m0.rvalid, m1.rvalid, m0.err}, 0);
    end
    @(posedge clk); #1;
    rst = 0; mon_en = 1;
    do_txn(vecs[0]);

    // back-to-back reads from port 0
    @(posedge clk); #1;
    drive(0, 1, 2'b10, 4'h0, 32'h00100004, 32'h0);
    gc.delete();
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (m0.gnt) begin
        if (gc.size() > 0) chk("b2b_rvalid_with_gnt", m0.rvalid, 1);
        gc.push_back(c);
      end
    end
    chk("b2b_count", gc.size(), 6);
    for (int i = 1; i < gc.size(); i++)
      chk("b2b_spacing", gc[i] - gc[i-1], 2);
    @(posedge clk); #1;
    drive(0, 0, 2'b00, 4'h0, 32'h0, 32'h0);
    repeat (4) @(negedge clk);

    // random traffic against the model
    g0 = 0; g1 = 0;
    for (int c = 0; c < 3000; c++) begin
      @(posedge clk); #1;
      if (!m0.req || g0) begin
        if ($urandom_range(0, 99) < 55) rnd_req(0);
        else drive(0, 0, 2'b00, 4'h0, 32'h0, 32'h0);
      end
      if (!m1.req || g1) begin
        if ($urandom_range(0, 99) < 55) rnd_req(1);
        else drive(1, 0, 2'b00, 4'h0, 32'h0, 32'h0);
      end
      @(negedge clk);
      g0 = m0.gnt; g1 = m1.gnt;
    end
    @(posedge clk); #1;
    drive(0, 0, 2'b00, 4'h0, 32'h0, 32'h0);
    drive(1, 0, 2'b00, 4'h0, 32'h0, 32'h0);
    repeat (4) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
